// File: rtl/rf_wb_seq.sv
// rf_wb_seq: buffers write-back results and sequences read-back/merge-write cycles into a 16x32 half-word RF.
// Optional macro RF_WB_FULLWORD_EN: mask 11 becomes a high-half then low-half merge write.
module rf_wb_seq #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic [1:0]  wb_mask,
  input  logic [3:0]  dec_rs1,
  input  logic [3:0]  dec_rs2,
  output logic        rd_hazard,
  output logic        rd_stall,
  output logic        rf_rd_valid,
  output logic        rf_we,
  output logic        rf_hl,
  output logic [3:0]  rf_write_reg,
  output logic [31:0] rf_data,
  output logic        wb_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef RF_WB_FULLWORD_EN
  localparam bit FULLWORD = 1'b1;
`else
  localparam bit FULLWORD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] data;
    logic [1:0]  mask;
  } entry_t;

  typedef enum logic [2:0] {IDLE, PREP, WR_H, PREP2, WR_L} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        in_entry;
  logic [1:0]    next_mask;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] hz_off;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  logic          seq_done;
  logic          fullword_err;

  assign wb_ready  = (count != CW'(DEPTH));
  assign push      = wb_valid && wb_ready;
  assign head      = mem[rd_ptr];
  assign next_mask = mem[AW'(rd_ptr + AW'(1))].mask;
  assign rd_stall  = rf_we;

  // Without full-word support a mask 11 result is reduced to its low half and flagged.
  always_comb begin
    in_entry     = '{rg: wb_reg, data: wb_data, mask: wb_mask};
    fullword_err = 1'b0;
    if (!FULLWORD && (wb_mask == 2'b11)) begin
      in_entry.mask = 2'b01;
      fullword_err  = 1'b1;
    end
  end

  // Hazard over every live entry that will actually write the RF.
  always_comb begin
    rd_hazard = 1'b0;
    hz_off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hz_off = AW'(i) - rd_ptr;
      if ((CW'(hz_off) < count) && (mem[i].mask != 2'b00) &&
          ((mem[i].rg == dec_rs1) || (mem[i].rg == dec_rs2)))
        rd_hazard = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    seq_done     = 1'b0;
    rf_we        = 1'b0;
    rf_hl        = 1'b0;
    rf_write_reg = '0;
    rf_data      = '0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          if (head.mask == 2'b00) pop = 1'b1;
          else                    state_nxt = PREP;
        end
      end
      PREP: begin
        rf_write_reg = head.rg;
        state_nxt    = (head.mask == 2'b01) ? WR_L : WR_H;
      end
      WR_H: begin
        rf_we        = 1'b1;
        rf_hl        = 1'b1;
        rf_write_reg = head.rg;
        rf_data      = head.data;
        if (FULLWORD && (head.mask == 2'b11)) state_nxt = PREP2;
        else                                  seq_done  = 1'b1;
      end
      PREP2: begin
        rf_write_reg = head.rg;
        state_nxt    = WR_L;
      end
      WR_L: begin
        rf_we        = 1'b1;
        rf_write_reg = head.rg;
        rf_data      = head.data;
        seq_done     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Chain straight into the next stored entry so back-to-back results leave no idle gap.
    if (seq_done) begin
      pop       = 1'b1;
      state_nxt = ((count > CW'(1)) && (next_mask != 2'b00)) ? PREP : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      rf_rd_valid <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rf_rd_valid <= ~rf_we;
      wb_err      <= push && fullword_err;
      if (push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
      if (push && !pop)      count <= CW'(count + CW'(1));
      else if (!push && pop) count <= CW'(count - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

endmodule

// File: doc/rf_wb_seq.md
# rf_wb_seq

Write-back sequencer between the execute/memory result path and the 16×32 register file. It buffers completed results and turns each one into the read-back/merge-write cycle sequence the register file needs. The register file writes only half-words, merged with the `out_reg3` value captured on an earlier non-write cycle. The block also gives decode a read-stall and a RAW-hazard indication.

## Interface
- `DEPTH`, 2, result buffer entries (power of two, ≥2)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `wb_valid`  in  1  result offered
- `wb_ready`  out  1  buffer can accept; `!full`, registered-state only
- `wb_reg`  in  4  destination register
- `wb_data`  in  32  result value
- `wb_mask`  in  2  bit0 = low half, bit1 = high half; 00 = no write
- `dec_rs1`, `dec_rs2`  in  4 each  decode source registers
- `rd_hazard`  out  1  a source matches a buffered entry with nonzero mask
- `rd_stall`  out  1  RF read ports unusable this cycle (`rf_we`=1)
- `rf_rd_valid`  out  1  RF `reg_out1/2` hold a fresh read this cycle
- `rf_we`  out  1  to RF `we`
- `rf_hl`  out  1  to RF `RF_HL` (1 = high half)
- `rf_write_reg`  out  4  to RF `write_reg`
- `rf_data`  out  32  to RF `data_in`
- `wb_err`  out  1  one-cycle pulse, unsupported mask dropped/reduced

## Operation
- FIFO of {reg, data, mask}. Push on `wb_valid && wb_ready`. Pop on the last cycle of the head's sequence. Push and pop in the same cycle are allowed; count is unchanged.
- FSM states: IDLE, PREP, WR_H, PREP2, WR_L. The state is registered. RF outputs decode from the state and the FIFO head only. There is no combinational path from `wb_*` to `rf_*`.
- IDLE: `rf_we`=0, `rf_write_reg`=0.
  - FIFO non-empty with head mask ≠00 → PREP.
  - Head mask 00 → pop in IDLE, stay IDLE, no RF activity.
- PREP/PREP2: `rf_we`=0, `rf_write_reg`=head.reg. The RF captures the target into `out_reg3`.
- PREP: mask 01 → WR_L; mask 10 or 11 → WR_H.
- WR_H: `rf_we`=1, `rf_hl`=1, `rf_data`=head.data. Mask 10 → pop, sequence done; mask 11 → PREP2 with no pop.
- PREP2 → WR_L. The second read-back picks up the new high half.
- WR_L: `rf_we`=1, `rf_hl`=0, `rf_data`=head.data → pop, sequence done.
- After a sequence completes, the next state is:
  - PREP if the next head exists with mask ≠00;
  - IDLE otherwise. A 00-mask head is then popped in IDLE.
- `rd_stall` = `rf_we`.
- `rf_rd_valid` is registered: 1 in the cycle after any cycle with `rf_we`=0 while out of reset.
- `rd_hazard` is combinational over all valid FIFO entries with mask ≠00, comparing against `dec_rs1` and `dec_rs2`. The head stays counted until it is popped.
- `rf_hl`=0 and `rf_data`=0 whenever `rf_we`=0.

## Timing
- Reset values:
  - `wb_ready`=1; `rd_hazard`=0 (FIFO empty).
  - `rd_stall`, `rf_rd_valid`, `rf_we`, `rf_hl`, `wb_err`=0.
  - `rf_write_reg`=0, `rf_data`=0, state IDLE.
- Reset mid-sequence aborts the sequence and discards all entries. The RF is cleared by its own reset.
- Latency from push edge E0, half-word entry on an idle block:
  - PREP in cycle E1–E2;
  - WR in cycle E2–E3, with the RF register updated at E3.
- Full-word entry: the register holds the final value at E5.
- Busy occupancy per entry: 2 cycles for a half-word, 4 for a full word, 1 IDLE cycle for mask 00.
- Full FIFO: `wb_ready`=0 even if a pop occurs this cycle.
- `wb_err` is asserted in the cycle after the offending push.

## Configuration
- `RF_WB_FULLWORD_EN` defined: mask 11 runs PREP→WR_H→PREP2→WR_L. `wb_err` is never asserted.
- Not defined:
  - PREP2 is unreachable.
  - A mask 11 push is stored as mask 01 (low half only) and `wb_err` pulses.

## Test plan
- Reset, then push r3 = 0x1234ABCD mask 01 → one PREP cycle (`rf_write_reg`=3, `rf_we`=0). Next cycle `rf_we`=1, `rf_hl`=0, `rf_data`=0x1234ABCD. r3 = 0x0000ABCD.
- r3 = 0x0000ABCD, push mask 10 data 0x5555FFFF → r3 = 0x5555ABCD. `rd_stall` is high for exactly one cycle.
- With the macro, push r7 = 0xDEADBEEF mask 11 onto r7 = 0 → state trace PREP, WR_H, PREP2, WR_L. r7 = 0xDEADBEEF. Without the macro: r7 = 0x0000BEEF and a single `wb_err` pulse.
- Hold `wb_valid` for 4 back-to-back half-word pushes with DEPTH=2 → `wb_ready` drops after 2 accepts. All 4 writes land in order, with no gap state between consecutive sequences.
- Buffer r5 pending, `dec_rs2`=5 → `rd_hazard`=1 until the WR_L pop. A mask 00 entry for r5 gives `rd_hazard`=0 and is popped in IDLE.
- Assert `reset` during WR_H of a full-word write → next cycle state IDLE, `wb_ready`=1, FIFO empty, `rf_we`=0.
